// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
//
// Registered RISC-V immediate generator for the ID stage. The opcode of the
// incoming instruction is decoded combinationally into a sign-extended
// immediate plus a format tag. Only the decoded result is buffered, in a
// two-entry arrangement (output register + skid register). This lets ready_o
// come straight from a flop, so there is no combinational path from ready_i to
// ready_o.
//
// Parameters
//   XLEN          datapath width, 32 or 64
//   BRANCH_SHIFT  1: B/J immediates are byte offsets (bit0 = 0)
//                 0: legacy halfword-offset packing (trailing zero dropped)
//
// Ports
//   clk_i    in   clock, rising edge
//   rst_i    in   asynchronous active-low reset
//   flush_i  in   synchronous flush of both entries and the current input beat
//   inst_i   in   32-bit instruction word
//   valid_i  in   inst_i valid
//   ready_o  out  block can accept (registered, = NOT skid valid)
//   imm_o    out  XLEN-bit immediate
//   fmt_o    out  format tag: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SH
//   unk_o    out  opcode not recognised (fmt NONE, imm 0)
//   valid_o  out  output entry valid
//   ready_i  in   downstream accepts
// -----------------------------------------------------------------------------
module imm_gen_pipe #(
  parameter int XLEN         = 32,
  parameter bit BRANCH_SHIFT = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic [31:0]     inst_i,
  input  logic            valid_i,
  output logic            ready_o,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      fmt_o,
  output logic            unk_o,
  output logic            valid_o,
  input  logic            ready_i
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_SH   = 3'd6;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  logic [6:0]      opcode;
  logic            is_shift;
  logic [XLEN-1:0] imm_i_fmt;
  logic [XLEN-1:0] imm_s_fmt;
  logic [XLEN-1:0] imm_b_fmt;
  logic [XLEN-1:0] imm_u_fmt;
  logic [XLEN-1:0] imm_j_fmt;
  logic [XLEN-1:0] imm_sh_fmt;
  logic [XLEN-1:0] imm_sh32_fmt;

  assign opcode   = inst_i[6:0];
  // SLLI / SRLI / SRAI share funct3 001 and 101; funct7 (incl. the SRA bit)
  // must never leak into the shift amount.
  assign is_shift = (inst_i[14:12] == 3'b001) || (inst_i[14:12] == 3'b101);

  // Sized casts of signed operands sign-extend to XLEN.
  assign imm_i_fmt = XLEN'($signed(inst_i[31:20]));
  assign imm_s_fmt = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
  assign imm_u_fmt = XLEN'($signed({inst_i[31:12], 12'b0}));

  assign imm_b_fmt = BRANCH_SHIFT
    ? XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}))
    : XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8]}));

  assign imm_j_fmt = BRANCH_SHIFT
    ? XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}))
    : XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21]}));

  // Shift amounts are zero-extended; RV64 OP-IMM uses a 6-bit shamt, while
  // the word-sized OP-IMM-32 shifts always use 5 bits.
  assign imm_sh_fmt   = (XLEN == 64) ? XLEN'(inst_i[25:20]) : XLEN'(inst_i[24:20]);
  assign imm_sh32_fmt = XLEN'(inst_i[24:20]);

  logic [XLEN-1:0] dec_imm_d;
  logic [2:0]      dec_fmt_d;
  logic            dec_unk_d;

  always_comb begin
    dec_imm_d = '0;
    dec_fmt_d = FMT_NONE;
    dec_unk_d = 1'b0;
    case (opcode)
      OP_LOAD, OP_JALR: begin
        dec_imm_d = imm_i_fmt;
        dec_fmt_d = FMT_I;
      end
      OP_IMM: begin
        if (is_shift) begin
          dec_imm_d = imm_sh_fmt;
          dec_fmt_d = FMT_SH;
        end else begin
          dec_imm_d = imm_i_fmt;
          dec_fmt_d = FMT_I;
        end
      end
      OP_IMM32: begin
        // Only meaningful on RV64; on RV32 it is an unknown opcode.
        if (XLEN == 64) begin
          if (is_shift) begin
            dec_imm_d = imm_sh32_fmt;
            dec_fmt_d = FMT_SH;
          end else begin
            dec_imm_d = imm_i_fmt;
            dec_fmt_d = FMT_I;
          end
        end else begin
          dec_unk_d = 1'b1;
        end
      end
      OP_STORE: begin
        dec_imm_d = imm_s_fmt;
        dec_fmt_d = FMT_S;
      end
      OP_BRANCH: begin
        dec_imm_d = imm_b_fmt;
        dec_fmt_d = FMT_B;
      end
      OP_LUI, OP_AUIPC: begin
        dec_imm_d = imm_u_fmt;
        dec_fmt_d = FMT_U;
      end
      OP_JAL: begin
        dec_imm_d = imm_j_fmt;
        dec_fmt_d = FMT_J;
      end
      default: begin
        dec_unk_d = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Two-entry buffer: output register + skid register
  // ---------------------------------------------------------------------------
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_imm_q;
  logic [2:0]      out_fmt_q;
  logic            out_unk_q;

  logic            skid_valid_q, skid_valid_d;
  logic [XLEN-1:0] skid_imm_q;
  logic [2:0]      skid_fmt_q;
  logic            skid_unk_q;

  logic accept;
  logic load_out_new;
  logic load_skid;
  logic move_skid;

  assign ready_o = ~skid_valid_q;
  assign accept  = valid_i & ready_o & ~flush_i;

  // New result goes straight to the output register if that slot is empty or
  // being consumed this cycle; otherwise it parks in the skid register.
  assign load_out_new = accept & (~out_valid_q | ready_i);
  assign load_skid    = accept & out_valid_q & ~ready_i;
  // While the skid is occupied ready_o is low, so this never coincides with
  // an accept.
  assign move_skid    = skid_valid_q & ready_i & ~flush_i;

  always_comb begin
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (move_skid) begin
      out_valid_d  = 1'b1;
      skid_valid_d = 1'b0;
    end else if (load_out_new) begin
      out_valid_d  = 1'b1;
    end else if (load_skid) begin
      skid_valid_d = 1'b1;
    end else if (ready_i) begin
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_fmt_q    <= FMT_NONE;
      out_unk_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_fmt_q   <= FMT_NONE;
      skid_unk_q   <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      if (move_skid) begin
        out_imm_q <= skid_imm_q;
        out_fmt_q <= skid_fmt_q;
        out_unk_q <= skid_unk_q;
      end else if (load_out_new) begin
        out_imm_q <= dec_imm_d;
        out_fmt_q <= dec_fmt_d;
        out_unk_q <= dec_unk_d;
      end
      if (load_skid) begin
        skid_imm_q <= dec_imm_d;
        skid_fmt_q <= dec_fmt_d;
        skid_unk_q <= dec_unk_d;
      end
    end
  end

  assign valid_o = out_valid_q;
  assign imm_o   = out_imm_q;
  assign fmt_o   = out_fmt_q;
  assign unk_o   = out_unk_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_pipe
//
// Three instances: A (XLEN=32, BRANCH_SHIFT=1), B (XLEN=32, BRANCH_SHIFT=0),
// C (XLEN=64, BRANCH_SHIFT=1). Stimulus pushes hand-computed expectations into
// a queue at the moment an input beat is accepted; a monitor pops and compares
// whenever any instance hands over an output.
// -----------------------------------------------------------------------------
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        flush;
  logic        ready;
  logic [31:0] inst;
  logic        vin [3];

  logic        rdy_a, rdy_b, rdy_c;
  logic        vo_a, vo_b, vo_c;
  logic [31:0] imm_a, imm_b;
  logic [63:0] imm_c;
  logic [2:0]  fmt_a, fmt_b, fmt_c;
  logic        unk_a, unk_b, unk_c;

  logic        rdy   [3];
  logic        vout  [3];
  logic [63:0] imm_w [3];
  logic [2:0]  fmt_w [3];
  logic        unk_w [3];

  assign rdy[0] = rdy_a;  assign rdy[1] = rdy_b;  assign rdy[2] = rdy_c;
  assign vout[0] = vo_a;  assign vout[1] = vo_b;  assign vout[2] = vo_c;
  assign imm_w[0] = {32'b0, imm_a};
  assign imm_w[1] = {32'b0, imm_b};
  assign imm_w[2] = imm_c;
  assign fmt_w[0] = fmt_a;  assign fmt_w[1] = fmt_b;  assign fmt_w[2] = fmt_c;
  assign unk_w[0] = unk_a;  assign unk_w[1] = unk_b;  assign unk_w[2] = unk_c;

  imm_gen_pipe #(.XLEN(32), .BRANCH_SHIFT(1'b1)) u_a (
    .clk_i(clk), .rst_i(rst_n), .flush_i(flush), .inst_i(inst), .valid_i(vin[0]),
    .ready_o(rdy_a), .imm_o(imm_a), .fmt_o(fmt_a), .unk_o(unk_a), .valid_o(vo_a),
    .ready_i(ready)
  );

  imm_gen_pipe #(.XLEN(32), .BRANCH_SHIFT(1'b0)) u_b (
    .clk_i(clk), .rst_i(rst_n), .flush_i(flush), .inst_i(inst), .valid_i(vin[1]),
    .ready_o(rdy_b), .imm_o(imm_b), .fmt_o(fmt_b), .unk_o(unk_b), .valid_o(vo_b),
    .ready_i(ready)
  );

  imm_gen_pipe #(.XLEN(64), .BRANCH_SHIFT(1'b1)) u_c (
    .clk_i(clk), .rst_i(rst_n), .flush_i(flush), .inst_i(inst), .valid_i(vin[2]),
    .ready_o(rdy_c), .imm_o(imm_c), .fmt_o(fmt_c), .unk_o(unk_c), .valid_o(vo_c),
    .ready_i(ready)
  );

  typedef struct {
    int          d;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        unk;
    int          stamp;
    bit          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: a handover happens at the next rising edge when valid_o & ready_i.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ready && !flush) begin
      for (int d = 0; d < 3; d++) begin
        if (vout[d]) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_out: dut %0d got imm=%h fmt=%0d, required no output",
                     d, imm_w[d], fmt_w[d]);
          end else begin
            e = exp_q.pop_front();
            $display("xact dut=%0d imm=%h fmt=%0d unk=%0d", d, imm_w[d], fmt_w[d], unk_w[d]);
            chk("dut_order", 64'(d), 64'(e.d));
            chk("imm", imm_w[d], e.imm);
            chk("fmt", 64'(fmt_w[d]), 64'(e.fmt));
            chk("unk", 64'(unk_w[d]), 64'(e.unk));
            if (e.lat) chk("latency", 64'(cyc - e.stamp), 64'd1);
          end
        end
      end
    end
  end

  // Offer one instruction to instance d, hold until accepted, push expectation.
  // Called and returns at posedge+1.
  task automatic send(input int d, input logic [31:0] w, input logic [63:0] ei,
                      input logic [2:0] ef, input logic eu, input bit lat);
    bit done = 1'b0;
    inst   = w;
    vin[d] = 1'b1;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (rdy[d] && !flush) begin
        exp_q.push_back('{d, ei, ef, eu, cyc, lat});
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    vin[d] = 1'b0;
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: dut %0d inst %h, ready_o never 1", d, w);
    end
  endtask

  // Let everything pending come out, then require an empty, idle instance.
  task automatic drain(input int d);
    ready = 1'b1;
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_valid_o", 64'(vout[d]), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b1;
    flush  = 1'b0;
    ready  = 1'b0;
    inst   = '0;
    vin[0] = 1'b0;
    vin[1] = 1'b0;
    vin[2] = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_valid_o", 64'(vo_a), 64'd0);
    chk("reset_ready_o", 64'(rdy_a), 64'd1);
    chk("reset_imm_o", imm_w[0], 64'd0);
    chk("reset_fmt_o", 64'(fmt_a), 64'd0);
    chk("reset_unk_o", 64'(unk_a), 64'd0);
    chk("reset_valid_o_c", 64'(vo_c), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Streaming on A with ready_i = 1, latency checked on every beat.
    ready = 1'b1;
    send(0, 32'hFFF00093, 64'h00000000FFFFFFFF, 3'd1, 1'b0, 1'b1); // addi -1
    send(0, 32'hFE112E23, 64'h00000000FFFFFFFC, 3'd2, 1'b0, 1'b1); // sw -4
    send(0, 32'hFE0008E3, 64'h00000000FFFFFFF0, 3'd3, 1'b0, 1'b1); // beq -16
    send(0, 32'h123450B7, 64'h0000000012345000, 3'd4, 1'b0, 1'b1); // lui
    send(0, 32'h4030D093, 64'h0000000000000003, 3'd6, 1'b0, 1'b1); // srai 3
    send(0, 32'hFF9FF06F, 64'h00000000FFFFFFF8, 3'd5, 1'b0, 1'b1); // jal -8
    send(0, 32'h00812083, 64'h0000000000000008, 3'd1, 1'b0, 1'b1); // lw 8
    send(0, 32'hFFFFF097, 64'h00000000FFFFF000, 3'd4, 1'b0, 1'b1); // auipc
    send(0, 32'hFFC08067, 64'h00000000FFFFFFFC, 3'd1, 1'b0, 1'b1); // jalr -4
    send(0, 32'h02109093, 64'h0000000000000001, 3'd6, 1'b0, 1'b1); // slli 5-bit shamt
    send(0, 32'h0010009B, 64'h0000000000000000, 3'd0, 1'b1, 1'b1); // addiw on RV32
    send(0, 32'h00000033, 64'h0000000000000000, 3'd0, 1'b1, 1'b1); // R-type: unknown
    drain(0);

    // Backpressure: two accepted, third refused until the skid drains.
    ready = 1'b0;
    send(0, 32'hFFF00093, 64'h00000000FFFFFFFF, 3'd1, 1'b0, 1'b0);
    send(0, 32'hFE112E23, 64'h00000000FFFFFFFC, 3'd2, 1'b0, 1'b0);
    inst   = 32'h123450B7;
    vin[0] = 1'b1;
    @(negedge clk);
    chk("full_ready_o", 64'(rdy_a), 64'd0);
    chk("full_valid_o", 64'(vo_a), 64'd1);
    chk("hold_imm_o", imm_w[0], 64'h00000000FFFFFFFF);
    @(posedge clk);
    #1;
    chk("hold_imm_stable", imm_w[0], 64'h00000000FFFFFFFF);
    ready = 1'b1;
    send(0, 32'h123450B7, 64'h0000000012345000, 3'd4, 1'b0, 1'b0);
    drain(0);

    // Flush with both entries full and a new beat offered in the same cycle.
    ready = 1'b0;
    send(0, 32'h00812083, 64'h0000000000000008, 3'd1, 1'b0, 1'b0);
    send(0, 32'hFFFFF097, 64'h00000000FFFFF000, 3'd4, 1'b0, 1'b0);
    inst   = 32'h4030D093;
    vin[0] = 1'b1;
    flush  = 1'b1;
    @(negedge clk);
    chk("preflush_ready_o", 64'(rdy_a), 64'd0);
    @(posedge clk);
    #1;
    flush  = 1'b0;
    vin[0] = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("flush_valid_o", 64'(vo_a), 64'd0);
    chk("flush_ready_o", 64'(rdy_a), 64'd1);
    @(posedge clk);
    #1;
    drain(0);

    // Asynchronous reset mid-stream, between clock edges, with both entries full.
    ready = 1'b0;
    send(0, 32'hFFF00093, 64'h00000000FFFFFFFF, 3'd1, 1'b0, 1'b0);
    send(0, 32'hFE112E23, 64'h00000000FFFFFFFC, 3'd2, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid_o", 64'(vo_a), 64'd0);
    chk("async_rst_ready_o", 64'(rdy_a), 64'd1);
    chk("async_rst_imm_o", imm_w[0], 64'd0);
    chk("async_rst_fmt_o", 64'(fmt_a), 64'd0);
    chk("async_rst_unk_o", 64'(unk_a), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready = 1'b1;
    send(0, 32'h00812083, 64'h0000000000000008, 3'd1, 1'b0, 1'b1);
    drain(0);

    // Legacy halfword packing.
    send(1, 32'hFF9FF06F, 64'h00000000FFFFFFFC, 3'd5, 1'b0, 1'b1); // jal -> -4
    send(1, 32'hFE0008E3, 64'h00000000FFFFFFF8, 3'd3, 1'b0, 1'b1); // beq -> -8
    send(1, 32'hFFF00093, 64'h00000000FFFFFFFF, 3'd1, 1'b0, 1'b1);
    drain(1);

    // RV64.
    send(2, 32'h0010009B, 64'h0000000000000001, 3'd1, 1'b0, 1'b1); // addiw 1
    send(2, 32'h800000B7, 64'hFFFFFFFF80000000, 3'd4, 1'b0, 1'b1); // lui
    send(2, 32'h02109093, 64'h0000000000000021, 3'd6, 1'b0, 1'b1); // slli 33
    send(2, 32'h0030909B, 64'h0000000000000003, 3'd6, 1'b0, 1'b1); // slliw 3
    send(2, 32'hFF9FF06F, 64'hFFFFFFFFFFFFFFF8, 3'd5, 1'b0, 1'b1); // jal -8
    drain(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Registered, parametrised RISC-V immediate generator for the ID stage. It decodes the opcode of an incoming instruction and produces the sign-extended immediate for every base format (I, S, B, U, J, plus shift-amount), together with a format tag. A valid/ready interface with a two-entry skid buffer decouples IF/ID from the ID/EX stall logic. Flush support drops wrong-path instructions.

## Interface
- XLEN, 32: datapath width; legal values 32 and 64. Sets the immediate width and the shamt width (5 bits at 32, 6 bits at 64).
- BRANCH_SHIFT, 1: 1 = B/J immediates are byte offsets with bit0 = 0; 0 = legacy packing {sext, inst[31], inst[7], inst[30:25], inst[11:8]}, i.e. the halfword offset.
- clk_i  in  1  clock; all state on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous flush; drops both buffered entries and any input beat in the same cycle.
- inst_i  in  32  instruction word.
- valid_i  in  1  inst_i valid.
- ready_o  out  1  block can accept; registered; equals NOT skid_valid.
- imm_o  out  XLEN  immediate.
- fmt_o  out  3  format tag: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SH.
- unk_o  out  1  opcode not recognised (fmt NONE, imm 0).
- valid_o  out  1  output entry valid.
- ready_i  in  1  downstream accepts.

## Operation
- Opcode decode on inst_i[6:0]. Let sx(v) denote sign extension to XLEN from v's MSB (inst[31]):
  - 0000011 LOAD, 1100111 JALR: I, sx(inst[31:20]).
  - 0010011 OP-IMM with funct3 001/101: SH, zero-extended inst[24:20] (XLEN=32) or inst[25:20] (XLEN=64). funct7 bits are never included.
  - 0010011 OP-IMM, other funct3: I.
  - 0011011 OP-IMM-32: recognised only when XLEN=64. funct3 001/101 gives SH using inst[24:20]; otherwise I. When XLEN=32 this opcode gives NONE with unk_o = 1.
  - 0100011 STORE: S, sx({inst[31:25], inst[11:7]}).
  - 1100011 BRANCH: B. With BRANCH_SHIFT=1: sx({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - 0110111 LUI, 0010111 AUIPC: U, sx({inst[31:12], 12'b0}). At XLEN=64 bits 63:32 replicate inst[31].
  - 1101111 JAL: J. With BRANCH_SHIFT=1: sx({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}). With BRANCH_SHIFT=0 the trailing 0 is dropped.
  - Any other opcode: NONE, imm 0, unk_o = 1.
- Decode is combinational from inst_i. Only the result {imm, fmt, unk} is stored, never the raw instruction.
- Storage: an output register (out_valid) and a skid register (skid_valid).
- Accept condition: valid_i & ready_o & ~flush_i.
- Accept when out_valid = 0 or ready_i = 1: the decoded result loads the output register.
- Accept when out_valid = 1 and ready_i = 0: the result loads the skid register and skid_valid is set.
- ready_i = 1 with skid_valid = 1: the skid moves to the output register and skid_valid clears. ready_o = 0 while skid_valid is set, so no new accept can occur in that cycle.
- ready_i = 1 with out_valid = 1, skid empty and no accept: out_valid clears.
- flush_i = 1: out_valid and skid_valid clear on the next edge. Flush overrides accept and drain. The data registers may keep stale contents.

## Timing
- Latency: 1 cycle from accept to valid_o. Throughput: 1 instruction per cycle while ready_i = 1.
- imm_o, fmt_o and unk_o stay stable while valid_o = 1 and ready_i = 0. No combinational path from ready_i to ready_o.
- Reset (rst_i = 0, asynchronous): valid_o = 0, skid_valid = 0, ready_o = 1, imm_o = 0, fmt_o = 0, unk_o = 0.
- Reset asserted mid-stream discards both entries immediately. The first accept after release appears on valid_o one cycle later.
- Full (both entries occupied): ready_o = 0. ready_o returns to 1 the cycle after ready_i drains the skid.
- ready_i asserted while valid_o = 0 has no effect.
- Flush and reset are the only ways to discard data. No entry is ever lost or duplicated.

## Test plan
- XLEN=32, BRANCH_SHIFT=1. Stream with ready_i = 1:
  - 0xFFF00093 (addi x1,x0,-1): imm 0xFFFFFFFF, fmt 1.
  - 0xFE112E23 (sw x1,-4(x2)): imm 0xFFFFFFFC, fmt 2.
  - 0xFE0008E3 (beq x0,x0,-16): imm 0xFFFFFFF0, fmt 3.
  - 0x123450B7 (lui): imm 0x12345000, fmt 4.
  - Each appears exactly 1 cycle after input.
- SH and J: 0x4030D093 (srai x1,x1,3) gives imm 3, fmt 6. 0xFF9FF06F (jal -8) gives imm 0xFFFFFFF8, fmt 5. With BRANCH_SHIFT=0, the same jal gives 0xFFFFFFFC.
- Backpressure: hold ready_i = 0 and offer 3 back-to-back valid instructions. First two are accepted, ready_o = 0 on the third. Release ready_i: outputs appear in order A, B, C with no loss or duplication.
- Flush: both entries full, assert flush_i together with valid_i. Next cycle valid_o = 0 and ready_o = 1; the flushed input never appears.
- XLEN=64: 0x0010009B (addiw) gives imm 1, fmt 1. 0x800000B7 (lui) gives 0xFFFFFFFF80000000. With XLEN=32, 0x0010009B gives unk_o = 1, imm 0.
- Reset: assert rst_i = 0 asynchronously between clock edges with valid_o = 1. All outputs return to reset values immediately, without waiting for a clock edge.
